// File: rtl/history_shift_mt.sv
`default_nettype none
// ============================================================================
// history_shift_mt : per-thread speculative branch history shift registers
//                    with misprediction recovery. Optional flush: HISTORY_FLUSH_EN
// Revision         : 1.0
// ============================================================================
module history_shift_mt #(
  parameter int HIST_W  = 32,
  parameter int NTHREAD = 4,
  localparam int TID_W  = (NTHREAD > 1) ? $clog2(NTHREAD) : 1,
  localparam int DEP_W  = $clog2(HIST_W + 1)
) (
  input  logic              clk,
  input  logic              areset_n,
`ifdef HISTORY_FLUSH_EN
  input  logic              flush_valid,
  input  logic [TID_W-1:0]  flush_tid,
`endif
  input  logic              predict_valid,
  input  logic [TID_W-1:0]  predict_tid,
  input  logic              predict_taken,
  output logic [HIST_W-1:0] predict_history,
  output logic [DEP_W-1:0]  predict_depth,
  input  logic              train_mispredicted,
  input  logic [TID_W-1:0]  train_tid,
  input  logic              train_taken,
  input  logic [HIST_W-1:0] train_history,
  input  logic [DEP_W-1:0]  train_depth
);

  localparam logic [DEP_W-1:0] c_depth_max = DEP_W'(HIST_W);

  logic [NTHREAD*HIST_W-1:0] w_hist_flat;
  logic [NTHREAD*DEP_W-1:0]  w_depth_flat;
  logic [HIST_W-1:0]         w_train_hist_next;
  logic [DEP_W-1:0]          w_train_depth_next;
  logic                      w_unused_train_msb;

  // The oldest snapshot bit falls off the end when the resolved direction is appended.
  assign w_unused_train_msb = train_history[HIST_W-1];
  assign w_train_hist_next  = {train_history[HIST_W-2:0], train_taken};
  assign w_train_depth_next = (train_depth >= c_depth_max) ? c_depth_max : train_depth + 1'b1;

  for (genvar t = 0; t < NTHREAD; t++) begin : g_thread
    logic [HIST_W-1:0] r_hist;
    logic [DEP_W-1:0]  r_depth;
    logic [DEP_W-1:0]  w_pred_depth_next;
    logic              w_pred_hit;
    logic              w_train_hit;
    logic              w_flush_hit;

    assign w_pred_hit  = predict_valid && (predict_tid == TID_W'(t));
    assign w_train_hit = train_mispredicted && (train_tid == TID_W'(t));
`ifdef HISTORY_FLUSH_EN
    assign w_flush_hit = flush_valid && (flush_tid == TID_W'(t));
`else
    assign w_flush_hit = 1'b0;
`endif
    assign w_pred_depth_next = (r_depth >= c_depth_max) ? c_depth_max : r_depth + 1'b1;

    always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
        r_hist  <= '0;
        r_depth <= '0;
      end else if (w_flush_hit) begin
        r_hist  <= '0;
        r_depth <= '0;
      end else if (w_train_hit) begin
        r_hist  <= w_train_hist_next;
        r_depth <= w_train_depth_next;
      end else if (w_pred_hit) begin
        r_hist  <= {r_hist[HIST_W-2:0], predict_taken};
        r_depth <= w_pred_depth_next;
      end
    end

    assign w_hist_flat[t*HIST_W +: HIST_W] = r_hist;
    assign w_depth_flat[t*DEP_W +: DEP_W]  = r_depth;
  end

  // Out-of-range thread ids match no entry and therefore read as zero.
  always_comb begin
    predict_history = '0;
    predict_depth   = '0;
    for (int t = 0; t < NTHREAD; t++) begin
      if (predict_tid == TID_W'(t)) begin
        predict_history = w_hist_flat[t*HIST_W +: HIST_W];
        predict_depth   = w_depth_flat[t*DEP_W +: DEP_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_history_shift_mt.sv
`default_nettype none
// Directed bench for history_shift_mt: HIST_W=32/NTHREAD=4 plus an NTHREAD=3 instance.
module tb_history_shift_mt;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;

  logic        predict_valid = 1'b0;
  logic [1:0]  predict_tid = '0;
  logic        predict_taken = 1'b0;
  logic [31:0] predict_history;
  logic [5:0]  predict_depth;
  logic        train_mispredicted = 1'b0;
  logic [1:0]  train_tid = '0;
  logic        train_taken = 1'b0;
  logic [31:0] train_history = '0;
  logic [5:0]  train_depth = '0;

  logic        p3_valid = 1'b0;
  logic [1:0]  p3_tid = '0;
  logic        p3_taken = 1'b0;
  logic [31:0] p3_history;
  logic [5:0]  p3_depth;
  logic        t3_valid = 1'b0;
  logic [1:0]  t3_tid = '0;
  logic        t3_taken = 1'b0;
  logic [31:0] t3_history = '0;
  logic [5:0]  t3_depth = '0;

`ifdef HISTORY_FLUSH_EN
  logic        flush_valid = 1'b0;
  logic [1:0]  flush_tid = '0;
  logic        f3_valid = 1'b0;
  logic [1:0]  f3_tid = '0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #10 clk = ~clk;

  history_shift_mt #(.HIST_W(32), .NTHREAD(4)) dut (
    .clk                (clk),
    .areset_n           (areset_n),
`ifdef HISTORY_FLUSH_EN
    .flush_valid        (flush_valid),
    .flush_tid          (flush_tid),
`endif
    .predict_valid      (predict_valid),
    .predict_tid        (predict_tid),
    .predict_taken      (predict_taken),
    .predict_history    (predict_history),
    .predict_depth      (predict_depth),
    .train_mispredicted (train_mispredicted),
    .train_tid          (train_tid),
    .train_taken        (train_taken),
    .train_history      (train_history),
    .train_depth        (train_depth)
  );

  history_shift_mt #(.HIST_W(32), .NTHREAD(3)) dut3 (
    .clk                (clk),
    .areset_n           (areset_n),
`ifdef HISTORY_FLUSH_EN
    .flush_valid        (f3_valid),
    .flush_tid          (f3_tid),
`endif
    .predict_valid      (p3_valid),
    .predict_tid        (p3_tid),
    .predict_taken      (p3_taken),
    .predict_history    (p3_history),
    .predict_depth      (p3_depth),
    .train_mispredicted (t3_valid),
    .train_tid          (t3_tid),
    .train_taken        (t3_taken),
    .train_history      (t3_history),
    .train_depth        (t3_depth)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    predict_valid      = 1'b0;
    train_mispredicted = 1'b0;
    p3_valid           = 1'b0;
    t3_valid           = 1'b0;
`ifdef HISTORY_FLUSH_EN
    flush_valid        = 1'b0;
    f3_valid           = 1'b0;
`endif
  endtask

  // Reads are only issued while no request is pending, so moving predict_tid is harmless.
  task automatic rd(input int tid, input logic [31:0] eh, input logic [5:0] ed, input string tag);
    predict_tid = 2'(tid);
    #1;
    chk({tag, "_hist"}, 64'(predict_history), 64'(eh));
    chk({tag, "_depth"}, 64'(predict_depth), 64'(ed));
  endtask

  task automatic rd3(input int tid, input logic [31:0] eh, input logic [5:0] ed, input string tag);
    p3_tid = 2'(tid);
    #1;
    chk({tag, "_hist"}, 64'(p3_history), 64'(eh));
    chk({tag, "_depth"}, 64'(p3_depth), 64'(ed));
  endtask

  task automatic pred(input int tid, input logic tk);
    predict_valid = 1'b1;
    predict_tid   = 2'(tid);
    predict_taken = tk;
    tick();
  endtask

  initial begin
    // Power-up reset, then release with no requests in flight.
    tick();
    tick();
    areset_n = 1'b1;
    tick();
    for (int t = 0; t < 4; t++) rd(t, 32'h0, 6'd0, "post_reset");

    pred(0, 1'b1);
    pred(0, 1'b0);
    pred(0, 1'b1);
    rd(0, 32'h5, 6'd3, "pred_101");

    // Asynchronous reset mid-cycle clears state without a clock edge.
    #4;
    areset_n = 1'b0;
    rd(0, 32'h0, 6'd0, "async_reset_t0");
    rd(1, 32'h0, 6'd0, "async_reset_t1");
    predict_valid = 1'b1;
    predict_tid   = 2'd0;
    predict_taken = 1'b1;
    tick();
    rd(0, 32'h0, 6'd0, "no_update_in_reset");
    areset_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) pred(1, 1'b1);
    pred(3, 1'b0);
    rd(1, 32'h0000000F, 6'd4, "setup_t1");

    for (int i = 0; i < 31; i++) pred(2, 1'b1);
    rd(2, 32'h7FFFFFFF, 6'd31, "sat_31");
    pred(2, 1'b1);
    pred(2, 1'b1);
    rd(2, 32'hFFFFFFFF, 6'd32, "sat_33");
    rd(0, 32'h0, 6'd0, "sat_t0_hold");
    rd(1, 32'h0000000F, 6'd4, "sat_t1_hold");
    rd(3, 32'h0, 6'd1, "sat_t3_hold");

    // Recovery beats prediction on the same thread.
    predict_valid      = 1'b1;
    predict_tid        = 2'd1;
    predict_taken      = 1'b1;
    train_mispredicted = 1'b1;
    train_tid          = 2'd1;
    train_history      = 32'h80000001;
    train_depth        = 6'd5;
    train_taken        = 1'b0;
    tick();
    rd(1, 32'h00000002, 6'd6, "collide_t1");
    rd(2, 32'hFFFFFFFF, 6'd32, "collide_t2_hold");

    train_mispredicted = 1'b1;
    train_tid          = 2'd0;
    train_history      = 32'h0000ABCD;
    train_depth        = 6'd10;
    train_taken        = 1'b1;
    tick();
    rd(0, 32'h0001579B, 6'd11, "recover_t0");

    // Prediction and recovery to different threads both land.
    predict_valid      = 1'b1;
    predict_tid        = 2'd0;
    predict_taken      = 1'b1;
    train_mispredicted = 1'b1;
    train_tid          = 2'd3;
    train_history      = 32'h12345678;
    train_depth        = 6'd40;
    train_taken        = 1'b1;
    tick();
    rd(0, 32'h0002AF37, 6'd12, "split_t0");
    rd(3, 32'h2468ACF1, 6'd32, "split_t3");
    rd(1, 32'h00000002, 6'd6, "split_t1_hold");

    train_mispredicted = 1'b1;
    train_tid          = 2'd2;
    train_history      = 32'h80000000;
    train_depth        = 6'd31;
    train_taken        = 1'b0;
    tick();
    rd(2, 32'h00000000, 6'd32, "train_depth_31");

    train_mispredicted = 1'b1;
    train_tid          = 2'd1;
    train_history      = 32'hFFFFFFFF;
    train_depth        = 6'd63;
    train_taken        = 1'b0;
    tick();
    rd(1, 32'hFFFFFFFE, 6'd32, "train_depth_63");

`ifdef HISTORY_FLUSH_EN
    flush_valid        = 1'b1;
    flush_tid          = 2'd2;
    train_mispredicted = 1'b1;
    train_tid          = 2'd2;
    train_history      = 32'h0F0F0F0F;
    train_depth        = 6'd7;
    train_taken        = 1'b1;
    predict_valid      = 1'b1;
    predict_tid        = 2'd0;
    predict_taken      = 1'b0;
    tick();
    rd(2, 32'h0, 6'd0, "flush_t2");
    rd(0, 32'h00055E6E, 6'd13, "flush_t0_pred");
`endif

    // NTHREAD=3 instance: thread id 3 is ignored and reads zero.
    p3_valid = 1'b1; p3_tid = 2'd0; p3_taken = 1'b1;
    tick();
    p3_valid = 1'b1; p3_tid = 2'd0; p3_taken = 1'b1;
    tick();
    rd3(0, 32'h3, 6'd2, "nt3_t0");
    p3_valid   = 1'b1;
    p3_tid     = 2'd3;
    p3_taken   = 1'b1;
    t3_valid   = 1'b1;
    t3_tid     = 2'd3;
    t3_history = 32'hDEADBEEF;
    t3_depth   = 6'd9;
    t3_taken   = 1'b1;
    #1;
    chk("oor_read_hist", 64'(p3_history), 64'h0);
    chk("oor_read_depth", 64'(p3_depth), 64'h0);
    tick();
    rd3(0, 32'h3, 6'd2, "oor_t0_hold");
    rd3(1, 32'h0, 6'd0, "oor_t1_hold");
    rd3(2, 32'h0, 6'd0, "oor_t2_hold");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/history_shift_mt.md
HISTORY_SHIFT_MT -- requirements
Module: history_shift_mt

Interface
REQ-001 Parameter HIST_W, default 32, history length in bits (legal range 2..64).
REQ-002 Parameter NTHREAD, default 4, number of independent thread histories (legal range 1..16; TID_W = max(1, clog2(NTHREAD))).
REQ-003 Local DEP_W = clog2(HIST_W+1), the width of the depth counters.
REQ-004 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 areset_n  input  1  asynchronous active-low reset.
REQ-007 predict_valid  input  1  speculative prediction update request.
REQ-008 predict_tid  input  TID_W  thread selected for prediction read/update.
REQ-009 predict_taken  input  1  predicted direction shifted in.
REQ-010 predict_history  output  HIST_W  current history of thread predict_tid.
REQ-011 predict_depth  output  DEP_W  count of valid bits in that history.
REQ-012 train_mispredicted  input  1  misprediction recovery request.
REQ-013 train_tid  input  TID_W  thread being recovered.
REQ-014 train_taken  input  1  resolved direction.
REQ-015 train_history  input  HIST_W  history snapshot at the mispredicted branch.
REQ-016 train_depth  input  DEP_W  depth snapshot at the mispredicted branch.

Function
REQ-017 State per thread t: hist[t] (HIST_W bits) and depth[t] (DEP_W bits).
REQ-018 predict_history SHALL equal hist[predict_tid] and predict_depth SHALL equal depth[predict_tid], combinationally from the current state (the pre-update value), regardless of predict_valid.
REQ-019 On a prediction update: hist <= {hist[HIST_W-2:0], predict_taken}, with the MSB discarded; depth <= min(depth+1, HIST_W).
REQ-020 On a recovery update: hist <= {train_history[HIST_W-2:0], train_taken}; depth <= min(train_depth+1, HIST_W).
REQ-021 A train_depth greater than HIST_W SHALL be treated as HIST_W.
REQ-022 Per-thread priority SHALL be flush (when compiled in), then recovery, then prediction, then hold; the lower-priority request to the same thread in the same cycle SHALL be dropped.
REQ-023 When predict_tid differs from train_tid, both updates SHALL apply in the same cycle, each to its own thread.
REQ-024 Threads not addressed by any request SHALL hold their state.
REQ-025 The block SHALL have no backpressure: every request is accepted in the cycle it is presented, and updates are visible on the outputs one cycle later (latency 1).
REQ-026 A predict_tid or train_tid of NTHREAD or above SHALL be ignored for updates, and the outputs for an out-of-range predict_tid SHALL read all-zero.

Reset
REQ-027 While areset_n is low, all hist[t] and depth[t] SHALL be 0 immediately, with no clock required; predict_history and predict_depth therefore read 0.
REQ-028 Reset assertion mid-update SHALL override everything, and no update SHALL occur on the first clock edge while areset_n is low.
REQ-029 Deassertion need not be synchronised internally; the system guarantees no requests in the cycle of deassertion.

Configuration
REQ-030 The macro HISTORY_FLUSH_EN, when defined, SHALL add the ports flush_valid (input, 1 bit) and flush_tid (input, TID_W bits).
REQ-031 With HISTORY_FLUSH_EN defined, flush_valid SHALL clear hist[flush_tid] and depth[flush_tid] to 0 at the next edge, overriding recovery and prediction to that thread.
REQ-032 With HISTORY_FLUSH_EN undefined, the flush ports SHALL be absent and the block behaves as if flush were never asserted.

Verification (HIST_W=32, NTHREAD=4)
REQ-033 Reset check: drive areset_n low mid-cycle -> all threads read history 0x00000000 and depth 0 immediately.
REQ-034 Depth saturation: 33 predictions of taken=1 to tid 2 -> history 0xFFFFFFFF, depth saturates at 32 without wrapping, and threads 0, 1 and 3 are unchanged.
REQ-035 Same-thread collision: thread 1 history 0x0000000F; same cycle predict(tid1, taken=1) and recovery(tid1, train_history=0x80000001, train_depth=5, train_taken=0) -> thread 1 history 0x00000002, depth 6.
REQ-036 Split-thread update: same cycle predict(tid0, taken=1) and recovery(tid3, train_history=0x12345678, train_depth=40, train_taken=1) -> tid0 history shifted by one with depth+1, tid3 history 0x2468ACF1, depth 32.
REQ-037 Flush (HISTORY_FLUSH_EN defined): same cycle flush tid2 and recovery tid2 -> tid2 history 0, depth 0.
REQ-038 Out-of-range thread: NTHREAD=3 with predict_tid=3 -> outputs read 0 and no state changes.
